// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle unsigned multiply/divide unit that owns the HI/LO pair for the
// EX stage. An accepted operation runs for WIDTH cycles with busy high. HI/LO
// are then written in one step and done pulses for one cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   start        request a new operation (accepted in IDLE or DONE only)
//   op           0 = MULT (unsigned), 1 = DIV (unsigned)
//   val1, val2   multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we MTHI / MTLO write enables (ignored while running)
//   wdata        MTHI / MTLO write data
//   busy         high while an operation is running
//   done         one-cycle pulse when HI/LO receive a new result
//   hi, lo       registered HI/LO contents
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   op_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;

    // One shared accumulator for both operations.
    //   MULT: {partial product high half, remaining multiplier bits}
    //   DIV : {partial remainder, remaining dividend / growing quotient}
    logic [2*WIDTH-1:0]     acc_q;
    logic [2*WIDTH-1:0]     acc_d;

    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         rem_try;
    logic [WIDTH-1:0]       rem_diff;
    logic [WIDTH-1:0]       rem_keep;
    logic                   rem_ge;

    always_comb begin
        // Shift-add: add the multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole accumulator right. The
        // carry lands in the top bit, so the 2W-bit product is kept intact.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, a_q} : '0);

        // Restoring step: shift the remainder left pulling in the next
        // dividend bit (W+1 bits), subtract when it fits. A zero divisor
        // always fits, yielding all-ones quotient and remainder = dividend.
        rem_try  = acc_q[2*WIDTH-1:WIDTH-1];
        rem_ge   = (rem_try >= {1'b0, b_q});
        rem_diff = rem_try[WIDTH-1:0] - b_q;
        rem_keep = rem_ge ? rem_diff : rem_try[WIDTH-1:0];

        if (op_q) begin
            acc_d = {rem_keep, acc_q[WIDTH-2:0], rem_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= val1;
                        b_q     <= val2;
                        cnt_q   <= '0;
                        acc_q   <= {{WIDTH{1'b0}}, (op ? val1 : val2)};
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        hi_q    <= acc_d[2*WIDTH-1:WIDTH];
                        lo_q    <= acc_d[WIDTH-1:0];
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle unsigned multiply/divide unit that owns the HI/LO register pair for the EX stage. It accepts an operation from the execute stage and runs for `WIDTH` cycles, stalling the pipeline through `busy`. It then writes HI/LO and serves them back to the pipeline on a read port for MFHI/MFLO. This makes it the consumer end of the HI/LO path that the single-cycle ALU only produces.

## Interface
- `WIDTH`, default 16: operand width; equals `WORD_LEN`. HI/LO are each `WIDTH` bits.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous reset, active-low.
- `start` input 1: request a new operation. Accepted only in IDLE or DONE.
- `op` input 1: operation select. 0 = MULT (unsigned), 1 = DIV (unsigned).
- `val1` input WIDTH: multiplicand / dividend.
- `val2` input WIDTH: multiplier / divisor.
- `hi_we`, `lo_we` input 1 each: MTHI / MTLO write enables.
- `wdata` input WIDTH: MTHI/MTLO write data.
- `busy` output 1: high while in the RUN state. The pipeline stalls EX on `busy`.
- `done` output 1: one-cycle pulse when HI/LO receive a new result.
- `hi`, `lo` output WIDTH: registered HI/LO contents.

## Operation
- States:
  - IDLE: reset state.
  - RUN: counter `cnt` counts from 0 to WIDTH-1.
  - DONE: one cycle only.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→RUN while `cnt` < WIDTH-1.
  - RUN→DONE when `cnt` == WIDTH-1.
  - DONE→RUN on `start`, else DONE→IDLE.
- Accept edge: latch `op`, `val1`, `val2` into internal registers and clear `cnt`. Later changes on the inputs have no effect on the running operation.
- MULT: shift-add over the 2·WIDTH-bit accumulator, one multiplier bit per RUN cycle. The full 2·WIDTH-bit product is never truncated. Result: HI = product[2W-1:W], LO = product[W-1:0].
- DIV: restoring division, one quotient bit per RUN cycle, using a W+1-bit partial remainder. Result: LO = quotient, HI = remainder.
- Divide by zero: runs the full WIDTH cycles, then LO = all ones, HI = `val1`. No exception is raised.
- HI/LO keep their previous values throughout RUN. They update only on the RUN→DONE edge.
- `start` while in RUN is ignored. No queueing, no abort.
- `hi_we`/`lo_we`:
  - In IDLE/DONE, write `wdata` into HI/LO at the next edge.
  - In RUN, ignored.
  - A write and `start` on the same edge: the write takes effect, and the operation's result later overwrites it.
  - A write in the DONE cycle coincides with no result write, so it takes effect normally.
- No `$display` or other simulation side effects in the RTL.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `cnt`=0, `busy`=0, `done`=0, `hi`=0, `lo`=0, internal operands=0.
- Reset deasserts synchronously to `clk` in the bench.
- Reset mid-RUN aborts immediately: HI/LO go to 0 and no `done` pulse follows.
- Latency, with `start` sampled at edge E0:
  - `busy`=1 from E0 through E(WIDTH). It is high for exactly WIDTH cycles.
  - HI/LO and `done` update at edge E(WIDTH).
  - `done`=1 for the single cycle after E(WIDTH).
- Back-to-back: `start` sampled during the DONE cycle begins the next operation with no idle bubble. `done` and the new `busy` cycle are adjacent.
- Outputs:
  - `busy` and `done` are decoded from the registered state only. No combinational path from inputs.
  - `hi`/`lo` come straight from registers. A read in the DONE cycle sees the new result.

## Test plan
- MULT 300 × 500 (0x012C × 0x01F4) -> after 16 busy cycles, `done` pulses, HI=0x0002, LO=0x49F0.
- MULT 0xFFFF × 0xFFFF -> HI=0xFFFE, LO=0x0001. DIV 1000 ÷ 7 issued in the DONE cycle -> starts immediately; LO=0x008E, HI=0x0006.
- DIV 0x1234 ÷ 0 -> after 16 cycles, LO=0xFFFF, HI=0x1234, `done`=1 for one cycle.
- MTHI 0xAAAA in IDLE -> `hi`=0xAAAA next cycle. Then start a MULT and assert `lo_we` with `start` low mid-RUN -> write ignored; final result wins.
- `start` pulsed again mid-RUN with different operands -> ignored; result matches the original operands; exactly one `done` pulse.
- `rst` low at RUN cycle 8 of a MULT -> `busy`, `done`, `hi`, `lo` = 0 immediately. After release, the unit is in IDLE and a new MULT 3 × 4 gives LO=0x000C, HI=0x0000.
